// File: rtl/sprite_compositor.sv
// sprite_compositor: per-pixel ROM address generator and priority layer mixer for a VGA scan
// Ports: Clk, Reset (sync, active-high); DrawX/DrawY/de current scan pixel; frame_tick one pulse per frame;
//   bird/pipe/gap/coin positions; *_addr registered ROM read addresses; *_q ROM data (1-cycle reads);
//   pix_idx/pix_layer/pix_valid mixed pixel, 3 cycles behind DrawX/DrawY/de.
module sprite_compositor #(
  parameter int BG_X0 = 120,
  parameter int BG_Y0 = 40,
  parameter int BG_W = 400,
  parameter int BG_H = 400,
  parameter int BIRD_W = 20,
  parameter int BIRD_H = 16,
  parameter int BIRD_FRAMES = 3,
  parameter int ANIM_DIV = 4,
  parameter int PIPE_W = 50,
  parameter int EDGE_OVH = 5,
  parameter int EDGE_H = 12,
  parameter int COIN_W = 16,
  parameter int COIN_H = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        de,
  input  logic        frame_tick,
  input  logic [9:0]  bird_x,
  input  logic [9:0]  bird_y,
  input  logic [10:0] pipe_x,
  input  logic [9:0]  gap_top,
  input  logic [9:0]  gap_bot,
  input  logic [9:0]  coin_x,
  input  logic [9:0]  coin_y,
  input  logic        coin_en,
  output logic [18:0] bg_addr,
  output logic [18:0] bird_addr,
  output logic [18:0] line_addr,
  output logic [18:0] edge_addr,
  output logic [18:0] coin_addr,
  input  logic [3:0]  bg_q,
  input  logic [3:0]  bird_q,
  input  logic [3:0]  line_q,
  input  logic [3:0]  edge_q,
  input  logic [3:0]  coin_q,
  output logic [3:0]  pix_idx,
  output logic [2:0]  pix_layer,
  output logic        pix_valid
);
  localparam int EDGE_W = PIPE_W + 2 * EDGE_OVH;
  logic [1:0] anim_cnt, frame;
  logic [10:0] bgx, bgy, bdx, bdy, cdx, cdy;
  logic [12:0] x, y, dx, ex, gt, gb, lt, bt, ly;
  logic body_y, top_lip, bot_lip;
  logic [4:0] hit, hit1, hit2;
  logic de1, de2;
  logic [18:0] bg_a, bird_a, line_a, edge_a, coin_a;
  logic [2:0] layer_n;
  logic [3:0] idx_n;
  // Differences are one bit wider than their operands so the top bit flags "left/above the sprite".
  // Pipe maths runs in 13 bits so X minus a negative pipe_x plus the lip overhang never wraps.
  always_comb begin
    bgx = {1'b0, DrawX} - 11'(BG_X0);
    bgy = {1'b0, DrawY} - 11'(BG_Y0);
    bdx = {1'b0, DrawX} - {1'b0, bird_x};
    bdy = {1'b0, DrawY} - {1'b0, bird_y};
    cdx = {1'b0, DrawX} - {1'b0, coin_x};
    cdy = {1'b0, DrawY} - {1'b0, coin_y};
    x = {3'b0, DrawX};
    y = {3'b0, DrawY};
    dx = x - {{2{pipe_x[10]}}, pipe_x};
    ex = dx + 13'(EDGE_OVH);
    gt = {3'b0, gap_top};
    gb = {3'b0, gap_bot};
    lt = gt - 13'(EDGE_H);
    bt = gb + 13'(EDGE_H);
    // A negative lip top means the top lip is clipped at row 0 and there is no body above it.
    body_y = (!lt[12] && y < lt) || y >= bt;
    top_lip = (lt[12] || y >= lt) && y < gt;
    bot_lip = y >= gb && y < bt;
    ly = top_lip ? y - lt : y - gb;
    hit[0] = !bgx[10] && bgx < 11'(BG_W) && !bgy[10] && bgy < 11'(BG_H);
    hit[1] = !dx[12] && dx < 13'(PIPE_W) && body_y;
    hit[2] = !ex[12] && ex < 13'(EDGE_W) && (top_lip || bot_lip);
    hit[3] = coin_en && !cdx[10] && cdx < 11'(COIN_W) && !cdy[10] && cdy < 11'(COIN_H);
    hit[4] = !bdx[10] && bdx < 11'(BIRD_W) && !bdy[10] && bdy < 11'(BIRD_H);
    bg_a = 19'(bgy) * 19'(BG_W) + 19'(bgx);
    bird_a = 19'(frame) * 19'(BIRD_W * BIRD_H) + 19'(bdy) * 19'(BIRD_W) + 19'(bdx);
    line_a = 19'(dx);
    edge_a = (ly >= 13'(EDGE_H / 2) ? 19'(EDGE_W) : 19'd0) + 19'(ex);
    coin_a = 19'(cdy) * 19'(COIN_W) + 19'(cdx);
  end
  // Sprite index 0 is transparent and falls through; background index 0 is drawn.
  always_comb begin
    layer_n = !de2 ? 3'd0 :
              (hit2[4] && bird_q != 4'd0) ? 3'd5 :
              (hit2[3] && coin_q != 4'd0) ? 3'd4 :
              (hit2[2] && edge_q != 4'd0) ? 3'd3 :
              (hit2[1] && line_q != 4'd0) ? 3'd2 :
              hit2[0] ? 3'd1 : 3'd0;
    idx_n = layer_n == 3'd5 ? bird_q :
            layer_n == 3'd4 ? coin_q :
            layer_n == 3'd3 ? edge_q :
            layer_n == 3'd2 ? line_q :
            layer_n == 3'd1 ? bg_q : 4'd0;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bg_addr <= '0;
      bird_addr <= '0;
      line_addr <= '0;
      edge_addr <= '0;
      coin_addr <= '0;
      hit1 <= '0;
      hit2 <= '0;
      de1 <= 1'b0;
      de2 <= 1'b0;
      pix_idx <= '0;
      pix_layer <= '0;
      pix_valid <= 1'b0;
      anim_cnt <= '0;
      frame <= '0;
    end else begin
      bg_addr <= hit[0] ? bg_a : '0;
      line_addr <= hit[1] ? line_a : '0;
      edge_addr <= hit[2] ? edge_a : '0;
      coin_addr <= hit[3] ? coin_a : '0;
      bird_addr <= hit[4] ? bird_a : '0;
      hit1 <= hit;
      hit2 <= hit1;
      de1 <= de;
      de2 <= de1;
      pix_idx <= idx_n;
      pix_layer <= layer_n;
      pix_valid <= de2;
      if (frame_tick) begin
        anim_cnt <= anim_cnt == 2'(ANIM_DIV - 1) ? 2'd0 : anim_cnt + 2'd1;
        if (anim_cnt == 2'(ANIM_DIV - 1))
          frame <= frame == 2'(BIRD_FRAMES - 1) ? 2'd0 : frame + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed vector table plus reset, latency and animation sequences
module tb_sprite_compositor;
  typedef struct {
    logic [9:0] x, y;
    logic de;
    logic [9:0] bx, by;
    logic [10:0] px;
    logic [9:0] gt, gb;
    logic ce;
    logic [9:0] cx, cy;
    logic [3:0] qbg, qbird, qline, qedge, qcoin;
    logic [18:0] abg, abird, aline, aedge, acoin;
    logic [3:0] idx;
    logic [2:0] layer;
  } vec_t;
  localparam logic [10:0] PF = 11'h60C;
  logic Clk = 1'b0, Reset = 1'b1, de = 1'b0, frame_tick = 1'b0, coin_en = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, bird_x = '0, bird_y = '0, gap_top = '0, gap_bot = '0;
  logic [9:0] coin_x = '0, coin_y = '0;
  logic [10:0] pipe_x = '0;
  logic [3:0] bg_q = '0, bird_q = '0, line_q = '0, edge_q = '0, coin_q = '0;
  logic [18:0] bg_addr, bird_addr, line_addr, edge_addr, coin_addr;
  logic [3:0] pix_idx;
  logic [2:0] pix_layer;
  logic pix_valid;
  int n_vec = 0, n_bad = 0;
  vec_t v[20];
  always #5 Clk = ~Clk;
  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .de(de), .frame_tick(frame_tick),
    .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .gap_top(gap_top), .gap_bot(gap_bot),
    .coin_x(coin_x), .coin_y(coin_y), .coin_en(coin_en),
    .bg_addr(bg_addr), .bird_addr(bird_addr), .line_addr(line_addr), .edge_addr(edge_addr),
    .coin_addr(coin_addr), .bg_q(bg_q), .bird_q(bird_q), .line_q(line_q), .edge_q(edge_q),
    .coin_q(coin_q), .pix_idx(pix_idx), .pix_layer(pix_layer), .pix_valid(pix_valid)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    DrawX = t.x; DrawY = t.y; de = t.de; bird_x = t.bx; bird_y = t.by; pipe_x = t.px;
    gap_top = t.gt; gap_bot = t.gb; coin_en = t.ce; coin_x = t.cx; coin_y = t.cy;
    bg_q = t.qbg; bird_q = t.qbird; line_q = t.qline; edge_q = t.qedge; coin_q = t.qcoin;
  endtask
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic tick;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask
  task automatic valid_after_reset(input string name);
    step(); chk({name, " valid c1"}, int'(pix_valid), 0);
    step(); chk({name, " valid c2"}, int'(pix_valid), 0);
    step(); chk({name, " valid c3"}, int'(pix_valid), 1);
  endtask
  initial begin
    v[0]  = '{120, 40, 1, 1000, 1000, PF, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 0, 0, 0, 0, 0, 3, 1};
    v[1]  = '{519, 439, 1, 1000, 1000, PF, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 159999, 0, 0, 0, 0, 3, 1};
    v[2]  = '{100, 40, 1, 1000, 1000, PF, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 0, 0, 0, 0, 0, 0, 0};
    v[3]  = '{520, 40, 1, 1000, 1000, PF, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 0, 0, 0, 0, 0, 0, 0};
    v[4]  = '{200, 439, 0, 1000, 1000, PF, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 159680, 0, 0, 0, 0, 0, 0};
    v[5]  = '{297, 145, 1, 1000, 1000, 300, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 42177, 0, 0, 62, 0, 11, 3};
    v[6]  = '{297, 100, 1, 1000, 1000, 300, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 24177, 0, 0, 0, 0, 3, 1};
    v[7]  = '{5, 10, 1, 1000, 1000, 11'h7D8, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 0, 0, 45, 0, 0, 10, 2};
    v[8]  = '{10, 10, 1, 1000, 1000, 11'h7D8, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 0, 0, 0, 0, 0, 0, 0};
    v[9]  = '{639, 10, 1, 1000, 1000, 639, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 0, 0, 0, 0, 0, 10, 2};
    v[10] = '{300, 261, 1, 1000, 1000, 300, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 88580, 0, 0, 65, 0, 11, 3};
    v[11] = '{349, 262, 1, 1000, 1000, 300, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 89029, 0, 49, 0, 0, 10, 2};
    v[12] = '{297, 145, 1, 1000, 1000, 300, 150, 250, 0, 0, 0, 3, 9, 10, 0, 12, 42177, 0, 0, 62, 0, 3, 1};
    v[13] = '{300, 138, 1, 1000, 1000, 300, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 39380, 0, 0, 5, 0, 11, 3};
    v[14] = '{405, 302, 1, 1000, 1000, PF, 150, 250, 1, 400, 300, 3, 9, 10, 11, 12, 105085, 0, 0, 0, 37, 12, 4};
    v[15] = '{405, 302, 1, 1000, 1000, PF, 150, 250, 0, 400, 300, 3, 9, 10, 11, 12, 105085, 0, 0, 0, 0, 3, 1};
    v[16] = '{300, 0, 1, 1000, 1000, 300, 5, 250, 0, 0, 0, 3, 9, 10, 11, 12, 0, 0, 0, 65, 0, 11, 3};
    v[17] = '{120, 40, 1, 1000, 1000, PF, 150, 250, 0, 0, 0, 0, 9, 10, 11, 12, 0, 0, 0, 0, 0, 0, 1};
    v[18] = '{205, 103, 1, 200, 100, PF, 150, 250, 0, 0, 0, 3, 9, 10, 11, 12, 25285, 65, 0, 0, 0, 9, 5};
    v[19] = '{205, 103, 1, 200, 100, 190, 150, 250, 0, 0, 0, 3, 0, 10, 11, 12, 25285, 65, 15, 0, 0, 10, 2};
    drive(v[0]);
    step();
    step();
    Reset = 1'b0;
    valid_after_reset("first");
    chk("first idx", int'(pix_idx), 3);
    chk("first layer", int'(pix_layer), 1);
    drive(v[1]);
    repeat (3) step();
    Reset = 1'b1;
    step();
    chk("rst valid", int'(pix_valid), 0);
    chk("rst layer", int'(pix_layer), 0);
    chk("rst idx", int'(pix_idx), 0);
    chk("rst bg_addr", int'(bg_addr), 0);
    step();
    Reset = 1'b0;
    valid_after_reset("resume");
    for (int i = 0; i < 20; i++) begin
      drive(v[i]);
      step();
      chk($sformatf("v%0d bg_addr", i), int'(bg_addr), int'(v[i].abg));
      chk($sformatf("v%0d bird_addr", i), int'(bird_addr), int'(v[i].abird));
      chk($sformatf("v%0d line_addr", i), int'(line_addr), int'(v[i].aline));
      chk($sformatf("v%0d edge_addr", i), int'(edge_addr), int'(v[i].aedge));
      chk($sformatf("v%0d coin_addr", i), int'(coin_addr), int'(v[i].acoin));
      step();
      step();
      chk($sformatf("v%0d pix_idx", i), int'(pix_idx), int'(v[i].idx));
      chk($sformatf("v%0d pix_layer", i), int'(pix_layer), int'(v[i].layer));
      chk($sformatf("v%0d pix_valid", i), int'(pix_valid), int'(v[i].de));
    end
    drive(v[18]);
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("anim tick %0d", t), int'(bird_addr), ((t / 4) % 3) * 320 + 65);
    end
    repeat (4) tick();
    chk("anim pre-reset", int'(bird_addr), 385);
    Reset = 1'b1;
    frame_tick = 1'b1;
    step();
    Reset = 1'b0;
    frame_tick = 1'b0;
    step();
    chk("anim reset wins", int'(bird_addr), 65);
    repeat (3) tick();
    chk("anim 3 after reset", int'(bird_addr), 65);
    tick();
    chk("anim 4 after reset", int'(bird_addr), 385);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
